pe_inject_scheduler: RTL and testbench
======================================

Name: pe_inject_scheduler

Overview:
- Sits between N local traffic sources inside a Node and the router's local injection port.
- Shares that single port between the sources with round-robin, wormhole-locked arbitration: once a packet's head is granted, the port stays with that source until its tail.
- Gates every injected flit on a credit counter that mirrors the router's local input buffer; the router returns one credit per freed slot.
- Output is registered and drives the router's local data and valid inputs directly.

Parameters:
- N, 4, number of requesting sources (2..8).
- FLIT_W, 20, flit width in bits.
- CREDITS, 4, depth of the router local input buffer; credit counter reset value.
- CW, 3, credit counter width; must satisfy 2^CW > CREDITS.

Ports:
- clk  in  1  clock.
- RST  in  1  synchronous active-high reset.
- req_flit  in  N*FLIT_W  flit offered by source i on bits [i*FLIT_W +: FLIT_W].
- req_valid  in  N  source i offers a flit.
- req_ready  out  N  source i's flit is accepted this cycle when req_valid[i] is also high (combinational).
- out_flit  out  FLIT_W  flit to the router local input.
- out_valid  out  1  out_flit is valid for exactly this cycle.
- credit_in  in  1  one-cycle pulse from the router: one buffer slot freed.
- grant_id  out  $clog2(N)  index of the currently locked source (valid while busy).
- busy  out  1  FSM is in LOCKED.
- credit_cnt  out  CW  current credit count.
- err_credit  out  1  sticky flag: credit returned while the counter is already at CREDITS.
- err_proto  out  1  sticky flag: a non-head flit offered while IDLE.

Behaviour:
- Flit type is carried in flit[19:18]: 2'b10 = HEAD, 2'b00 = BODY, 2'b01 = TAIL, 2'b11 = SINGLE (head and tail in one flit). Remaining bits are opaque payload and are passed through unchanged.
- Reset (RST high at a clock edge), all synchronous:
  - state = IDLE, rr_ptr = 0, credit_cnt = CREDITS, out_valid = 0, out_flit = 0, grant_id = 0, busy = 0, err_credit = 0, err_proto = 0.
  - A reset mid-packet abandons the packet; sources are reset by the same RST.
- Eligibility: a flit can only be accepted when credit_cnt != 0. A credit arriving in the same cycle does not make the current cycle eligible.
- State IDLE:
  - Candidates are sources with req_valid high and flit type HEAD or SINGLE.
  - The winner is the first candidate found scanning from rr_ptr upward, wrapping modulo N.
  - If credits are available, req_ready[winner] = 1 in the same cycle.
  - Accepted HEAD -> state LOCKED, grant_id = winner.
  - Accepted SINGLE -> stay in IDLE, rr_ptr = winner + 1 (mod N).
  - A valid BODY or TAIL flit offered in IDLE is never accepted and sets err_proto.
- State LOCKED:
  - Only req_ready[grant_id] can be high, and only when req_valid[grant_id] is high and credits are available.
  - Other sources are ignored.
  - Accepted TAIL -> state IDLE, rr_ptr = grant_id + 1 (mod N).
  - Accepted BODY -> stay in LOCKED.
  - An accepted HEAD or SINGLE while LOCKED sets err_proto; the flit is forwarded and the lock is kept.
- Latency: a flit accepted in cycle t appears on out_flit with out_valid = 1 in cycle t+1. out_valid is low in every cycle that follows a cycle with no acceptance. At most one flit is accepted per cycle.
- Credit arithmetic, per cycle:
  - Accept only: credit_cnt decrements.
  - credit_in only: credit_cnt increments.
  - Both in the same cycle: credit_cnt is unchanged.
  - credit_in with credit_cnt == CREDITS and no accept: the count saturates and err_credit sets.
- err_credit and err_proto are cleared only by RST.
- Starvation: an unbounded-length packet holds the port. The round-robin advance guarantees every source is served within N packets.

Decomposition:
- Shared package noc_pkg holds:
  - FLIT_W = 20.
  - Flit-type field position [19:18].
  - Type constants FT_HEAD, FT_BODY, FT_TAIL, FT_SINGLE.
  - State encoding for IDLE and LOCKED.
- One natural sub-module, rr_arbiter: a combinational N-way round-robin priority selector with inputs req[N] and ptr, and outputs gnt one-hot, gnt_idx and any.
- The FSM, credit counter and output register stay in pe_inject_scheduler.

Test Plan:
- Single packet: N=4, CREDITS=4. Source 2 sends HEAD/BODY/TAIL back-to-back from cycle 0.
  - Required: req_ready[2] high cycles 0–2.
  - Required: out_valid high cycles 1–3 with the same flits in order.
  - Required: credit_cnt goes 4→1; busy high cycles 1–2 and low at cycle 3.
- Credit stall: CREDITS=2, source 0 sends a 4-flit packet with no credit_in.
  - Required: 2 flits are accepted, then req_ready[0] stays 0.
  - Then pulse credit_in at cycle 5: credit_cnt = 1 at cycle 6, the 3rd flit is accepted at cycle 6 and output at cycle 7.
- Round-robin fairness: sources 0, 1 and 3 each continuously offer SINGLE flits, with ample credit_in.
  - Required: grant order 0, 1, 3, 0, 1, 3.
- Wormhole lock: source 1 is mid-packet (LOCKED) while source 0 offers a HEAD.
  - Required: req_ready[0] stays 0 until source 1's TAIL is accepted.
  - Then the next grant goes to source 2/3 if valid, otherwise to source 0.
- Simultaneous accept and credit return with credit_cnt = 3: required credit_cnt remains 3.
  - Then credit_in with credit_cnt = 4 and idle: required credit_cnt stays 4 and err_credit = 1.
- Protocol and reset:
  - A BODY flit offered in IDLE: required no accept and err_proto = 1.
  - RST asserted while LOCKED after 2 flits: next cycle state IDLE, credit_cnt = CREDITS, out_valid = 0, both error flags = 0.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC definitions for the local injection path.
// Holds the flit width, where the flit-type field sits inside a flit,
// the flit-type codes and the injection scheduler state encoding.
package noc_pkg;

  localparam int FLIT_W = 20;
  localparam int FT_MSB = 19;
  localparam int FT_LSB = 18;

  typedef enum logic [1:0] {
    FT_BODY   = 2'b00,
    FT_TAIL   = 2'b01,
    FT_HEAD   = 2'b10,
    FT_SINGLE = 2'b11
  } flit_type_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } sched_state_e;

  // Pulls the two type bits out of a flit; payload bits are ignored.
  function automatic flit_type_e flitType(input logic [FLIT_W-1:0] flit);
    return flit_type_e'(flit[FT_MSB:FT_LSB]);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational N-way round-robin priority selector.
// Ports:
//   req     - one request bit per source
//   ptr     - index of the source holding highest priority this cycle
//   gnt     - one-hot grant, all zero when nothing requests
//   gnt_idx - binary index of the granted source (0 when any is low)
//   any     - at least one source is requesting
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  // Walk the sources starting at ptr and wrapping around; the first
  // requester met wins, so priority rotates with the pointer.
  always_comb begin
    int idx;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!any && req[idx]) begin
        any          = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/pe_inject_scheduler.sv
// Shares the router's local injection port between N local sources.
// Packets are granted round-robin and the port stays locked to the
// granted source from head to tail. Every accepted flit spends one
// credit that mirrors a slot of the router's local input buffer.
// Ports:
//   clk, RST    - clock and synchronous active-high reset
//   req_flit    - flit from source i on bits [i*FLIT_W +: FLIT_W]
//   req_valid   - source i offers a flit
//   req_ready   - source i's flit is taken this cycle (combinational)
//   out_flit    - registered flit to the router local input
//   out_valid   - out_flit is valid this cycle
//   credit_in   - router freed one buffer slot
//   grant_id    - source currently holding the lock
//   busy        - a packet is in flight (LOCKED)
//   credit_cnt  - credits currently available
//   err_credit  - sticky: credit returned while already full
//   err_proto   - sticky: packet framing violation seen
module pe_inject_scheduler #(
  parameter int N       = 4,
  parameter int FLIT_W  = 20,
  parameter int CREDITS = 4,
  parameter int CW      = 3,
  parameter int IW      = $clog2(N)
) (
  input  logic                clk,
  input  logic                RST,
  input  logic [N*FLIT_W-1:0] req_flit,
  input  logic [N-1:0]        req_valid,
  output logic [N-1:0]        req_ready,
  output logic [FLIT_W-1:0]   out_flit,
  output logic                out_valid,
  input  logic                credit_in,
  output logic [IW-1:0]       grant_id,
  output logic                busy,
  output logic [CW-1:0]       credit_cnt,
  output logic                err_credit,
  output logic                err_proto
);

  import noc_pkg::*;

  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

  sched_state_e      state_q, state_d;
  logic [IW-1:0]     rrPtr_q, rrPtr_d;
  logic [IW-1:0]     grant_q, grant_d;
  logic [CW-1:0]     credit_q;
  logic [FLIT_W-1:0] outFlit_q;
  logic              outValid_q, errCredit_q, errProto_q;

  flit_type_e        srcType [N];
  logic [N-1:0]      headLike;
  logic [N-1:0]      candidate;
  logic [N-1:0]      arbGnt;
  logic [IW-1:0]     arbIdx;
  logic              arbAny;
  logic              creditOk;
  logic              accept;
  logic              protoSet;
  logic [IW-1:0]     selIdx;
  logic [FLIT_W-1:0] selFlit;

  function automatic logic [IW-1:0] nextIdx(input logic [IW-1:0] i);
    return (i == IW'(N-1)) ? '0 : i + 1'b1;
  endfunction

  // Classify each offered flit. Only HEAD and SINGLE flits may open a
  // packet, so only those compete for the port while idle.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      srcType[i]   = flitType(req_flit[i*FLIT_W +: FLIT_W]);
      headLike[i]  = (srcType[i] == FT_HEAD) || (srcType[i] == FT_SINGLE);
      candidate[i] = req_valid[i] && headLike[i];
    end
  end

  rr_arbiter #(.N(N), .IW(IW)) u_arb (
    .req     (candidate),
    .ptr     (rrPtr_q),
    .gnt     (arbGnt),
    .gnt_idx (arbIdx),
    .any     (arbAny)
  );

  // A credit arriving this cycle is only usable next cycle, so
  // eligibility looks at the registered count alone.
  assign creditOk = (credit_q != '0);
  assign selFlit  = req_flit[selIdx*FLIT_W +: FLIT_W];

  // Next-state and handshake logic. While idle the arbiter picks the
  // packet opener; once a HEAD is taken only the owner is listened to
  // until its TAIL goes through, and the pointer then moves past the
  // owner so the next packet starts with its neighbour.
  always_comb begin
    state_d   = state_q;
    rrPtr_d   = rrPtr_q;
    grant_d   = grant_q;
    req_ready = '0;
    accept    = 1'b0;
    protoSet  = 1'b0;
    selIdx    = grant_q;
    case (state_q)
      ST_IDLE: begin
        protoSet = |(req_valid & ~headLike);
        if (arbAny && creditOk) begin
          req_ready = arbGnt;
          accept    = 1'b1;
          selIdx    = arbIdx;
          if (srcType[arbIdx] == FT_HEAD) begin
            state_d = ST_LOCKED;
            grant_d = arbIdx;
          end else begin
            rrPtr_d = nextIdx(arbIdx);
          end
        end
      end
      ST_LOCKED: begin
        if (req_valid[grant_q] && creditOk) begin
          req_ready[grant_q] = 1'b1;
          accept             = 1'b1;
          case (srcType[grant_q])
            FT_TAIL: begin
              state_d = ST_IDLE;
              rrPtr_d = nextIdx(grant_q);
            end
            FT_BODY: ;
            default: protoSet = 1'b1;
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, output register, credit counter and sticky error flags.
  // Accept and credit return in the same cycle cancel out; a return
  // with the counter already full saturates and flags the router.
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      rrPtr_q     <= '0;
      grant_q     <= '0;
      credit_q    <= CRED_MAX;
      outFlit_q   <= '0;
      outValid_q  <= 1'b0;
      errCredit_q <= 1'b0;
      errProto_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rrPtr_q    <= rrPtr_d;
      grant_q    <= grant_d;
      outValid_q <= accept;
      if (accept) outFlit_q <= selFlit;
      if (protoSet) errProto_q <= 1'b1;
      case ({accept, credit_in})
        2'b10: credit_q <= credit_q - 1'b1;
        2'b01: begin
          if (credit_q == CRED_MAX) errCredit_q <= 1'b1;
          else credit_q <= credit_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign out_flit   = outFlit_q;
  assign out_valid  = outValid_q;
  assign grant_id   = grant_q;
  assign busy       = (state_q == ST_LOCKED);
  assign credit_cnt = credit_q;
  assign err_credit = errCredit_q;
  assign err_proto  = errProto_q;

endmodule

// File: tb/tb_pe_inject_scheduler.sv
// Self-checking bench for pe_inject_scheduler: directed scenarios
// followed by randomized traffic, all compared against a packet-level
// model of sources, arbitration and the router credit pool.
module tb_pe_inject_scheduler;

  localparam int N       = 4;
  localparam int FLIT_W  = 20;
  localparam int CREDITS = 4;
  localparam int CW      = 3;
  localparam int IW      = 2;

  logic                clk = 1'b0;
  logic                RST;
  logic [N*FLIT_W-1:0] req_flit;
  logic [N-1:0]        req_valid;
  logic [N-1:0]        req_ready;
  logic [FLIT_W-1:0]   out_flit;
  logic                out_valid;
  logic                credit_in;
  logic [IW-1:0]       grant_id;
  logic                busy;
  logic [CW-1:0]       credit_cnt;
  logic                err_credit;
  logic                err_proto;

  pe_inject_scheduler #(.N(N), .FLIT_W(FLIT_W), .CREDITS(CREDITS), .CW(CW)) dut (
    .clk        (clk),
    .RST        (RST),
    .req_flit   (req_flit),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .out_flit   (out_flit),
    .out_valid  (out_valid),
    .credit_in  (credit_in),
    .grant_id   (grant_id),
    .busy       (busy),
    .credit_cnt (credit_cnt),
    .err_credit (err_credit),
    .err_proto  (err_proto)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  logic [FLIT_W-1:0] srcQ [N][$];
  logic [N-1:0]      srcEn;
  int                grantLog[$];

  bit                mLocked;
  int                mOwner, mPtr, mCred;
  bit                mErrC, mErrP, mOutValid;
  logic [FLIT_W-1:0] mOutFlit;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [FLIT_W-1:0] mk(input logic [1:0] ft, input int pl);
    logic [17:0] p;
    p = 18'(pl);
    return {ft, p};
  endfunction

  // Queue one packet of len flits on source s (len 1 is a SINGLE).
  task automatic pushPacket(input int s, input int len, input int tag);
    if (len == 1) srcQ[s].push_back(mk(2'b11, tag));
    else begin
      srcQ[s].push_back(mk(2'b10, tag));
      for (int k = 1; k < len - 1; k++) srcQ[s].push_back(mk(2'b00, tag + k));
      srcQ[s].push_back(mk(2'b01, tag + len - 1));
    end
  endtask

  // Drive one cycle of inputs, compare every output with the model,
  // clock, then advance the model by what the rules say happened.
  task automatic applyStimulus(input bit credit);
    logic [N-1:0]      v;
    logic [N-1:0]      expReady;
    logic [FLIT_W-1:0] f;
    logic [1:0]        ft;
    int                win;
    for (int i = 0; i < N; i++) begin
      v[i] = srcEn[i] && (srcQ[i].size() > 0);
      req_flit[i*FLIT_W +: FLIT_W] = v[i] ? srcQ[i][0] : '0;
    end
    req_valid = v;
    credit_in = credit;
    #1;
    win = -1;
    if (!mLocked) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (mPtr + k) % N;
        if (win < 0 && v[idx] && srcQ[idx][0][19]) win = idx;
      end
    end else if (v[mOwner]) win = mOwner;
    if (mCred == 0) win = -1;
    expReady = '0;
    if (win >= 0) expReady[win] = 1'b1;
    checkOutput("req_ready", 32'(req_ready), 32'(expReady));
    checkOutput("out_valid", 32'(out_valid), 32'(mOutValid));
    if (mOutValid) checkOutput("out_flit", 32'(out_flit), 32'(mOutFlit));
    checkOutput("credit_cnt", 32'(credit_cnt), 32'(mCred));
    checkOutput("busy", 32'(busy), 32'(mLocked));
    if (mLocked) checkOutput("grant_id", 32'(grant_id), 32'(mOwner));
    checkOutput("err_credit", 32'(err_credit), 32'(mErrC));
    checkOutput("err_proto", 32'(err_proto), 32'(mErrP));
    @(posedge clk);
    if (!mLocked)
      for (int i = 0; i < N; i++) if (v[i] && !srcQ[i][0][19]) mErrP = 1;
    if (win >= 0 && !credit) mCred--;
    else if (win < 0 && credit) begin
      if (mCred == CREDITS) mErrC = 1;
      else mCred++;
    end
    if (win >= 0) begin
      f = srcQ[win].pop_front();
      ft = f[19:18];
      mOutValid = 1;
      mOutFlit = f;
      grantLog.push_back(win);
      if (!mLocked) begin
        if (ft == 2'b10) begin
          mLocked = 1;
          mOwner = win;
        end else mPtr = (win + 1) % N;
      end else begin
        if (ft == 2'b01) begin
          mLocked = 0;
          mPtr = (mOwner + 1) % N;
        end else if (ft[1]) mErrP = 1;
      end
    end else mOutValid = 0;
    #1;
  endtask

  // Reset with whatever inputs are currently driven, then confirm the
  // documented reset state.
  task automatic doReset();
    RST = 1'b1;
    @(posedge clk);
    #1;
    RST = 1'b0;
    for (int i = 0; i < N; i++) srcQ[i].delete();
    req_valid = '0;
    req_flit  = '0;
    credit_in = 1'b0;
    mLocked = 0; mOwner = 0; mPtr = 0; mCred = CREDITS;
    mErrC = 0; mErrP = 0; mOutValid = 0; mOutFlit = '0;
    #1;
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_credit", 32'(credit_cnt), CREDITS);
    checkOutput("rst_out_valid", 32'(out_valid), 0);
    checkOutput("rst_out_flit", 32'(out_flit), 0);
    checkOutput("rst_grant_id", 32'(grant_id), 0);
    checkOutput("rst_err_credit", 32'(err_credit), 0);
    checkOutput("rst_err_proto", 32'(err_proto), 0);
  endtask

  task automatic runUntilEmpty(input bit credit);
    for (int c = 0; c < 40; c++) begin
      bit empty;
      empty = 1;
      for (int i = 0; i < N; i++) if (srcQ[i].size() > 0) empty = 0;
      if (empty) break;
      applyStimulus(credit);
    end
  endtask

  task automatic refillCredits();
    for (int c = 0; c < CREDITS && mCred < CREDITS; c++) applyStimulus(1'b1);
  endtask

  // Directed scenarios then randomized traffic.
  initial begin
    int expOrder[$];
    RST = 1'b1; req_valid = '0; req_flit = '0; credit_in = 1'b0; srcEn = '1;
    doReset();

    $display("[TB] single packet from source 2");
    pushPacket(2, 3, 16'h111);
    repeat (4) applyStimulus(1'b0);
    checkOutput("pkt_credit_end", 32'(credit_cnt), 1);
    refillCredits();

    $display("[TB] credit stall");
    pushPacket(0, 6, 16'h200);
    repeat (5) applyStimulus(1'b0);
    applyStimulus(1'b1);
    checkOutput("stall_credit_one", 32'(credit_cnt), 1);
    runUntilEmpty(1'b1);
    refillCredits();

    $display("[TB] round-robin fairness");
    doReset();
    grantLog.delete();
    for (int r = 0; r < 2; r++) begin
      pushPacket(0, 1, 16'h300 + r);
      pushPacket(1, 1, 16'h310 + r);
      pushPacket(3, 1, 16'h330 + r);
    end
    repeat (6) applyStimulus(1'b1);
    expOrder = '{0, 1, 3, 0, 1, 3};
    checkOutput("rr_count", 32'(grantLog.size()), 6);
    for (int k = 0; k < 6 && k < grantLog.size(); k++)
      checkOutput($sformatf("rr_order%0d", k), 32'(grantLog[k]), 32'(expOrder[k]));

    $display("[TB] wormhole lock");
    grantLog.delete();
    pushPacket(1, 4, 16'h410);
    applyStimulus(1'b1);
    pushPacket(0, 2, 16'h400);
    pushPacket(3, 1, 16'h430);
    runUntilEmpty(1'b1);
    expOrder = '{1, 1, 1, 1, 3, 0, 0};
    checkOutput("lock_count", 32'(grantLog.size()), 7);
    for (int k = 0; k < 7 && k < grantLog.size(); k++)
      checkOutput($sformatf("lock_order%0d", k), 32'(grantLog[k]), 32'(expOrder[k]));

    $display("[TB] credit arithmetic");
    doReset();
    pushPacket(0, 1, 16'h500);
    applyStimulus(1'b0);
    pushPacket(0, 1, 16'h501);
    applyStimulus(1'b1);
    checkOutput("acc_and_credit", 32'(credit_cnt), 3);
    applyStimulus(1'b1);
    applyStimulus(1'b1);
    checkOutput("sat_credit", 32'(credit_cnt), 4);
    checkOutput("sat_err_credit", 32'(err_credit), 1);

    $display("[TB] protocol error and mid-packet reset");
    srcQ[2].push_back(mk(2'b00, 16'h600));
    applyStimulus(1'b0);
    checkOutput("proto_err", 32'(err_proto), 1);
    checkOutput("proto_no_out", 32'(out_valid), 0);
    srcQ[2].delete();
    pushPacket(1, 5, 16'h610);
    repeat (2) applyStimulus(1'b0);
    checkOutput("pre_rst_busy", 32'(busy), 1);
    for (int i = 0; i < N; i++) req_valid[i] = (srcQ[i].size() > 0);
    doReset();
    applyStimulus(1'b0);

    $display("[TB] randomized traffic");
    for (int c = 0; c < 1500; c++) begin
      srcEn = N'($urandom);
      for (int i = 0; i < N; i++)
        if (srcQ[i].size() == 0 && $urandom_range(0, 2) != 0)
          pushPacket(i, $urandom_range(1, 4), int'($urandom_range(0, 16'hffff)));
      applyStimulus((mCred < CREDITS) && ($urandom_range(0, 1) == 1));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
